seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Sequential restoring divider, the inverse operation of the team's 16x16 approximate array multiplier.
- Takes a 2N-bit dividend (a full multiplier product width) and an N-bit divisor.
- Returns an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Sits after the multiplier datapath for ratio/normalisation use; ready/valid on both sides.

Parameters:
- N, 16, divisor/quotient/remainder width; dividend is 2N.
- APPROX_BITS, 4, quotient LSBs skipped when APPROX_DIV_EN is defined; legal range 0..N-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operation
- dividend  input  2N  unsigned dividend
- divisor  input  N  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_zero  output  1  divisor was 0
- overflow  output  1  quotient would not fit in N bits

Behaviour:
- One clock; reset asynchronous active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0, iteration counter 0.
- Reset asserted mid-operation aborts immediately; the result is discarded.
- States: IDLE, CALC, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE, on in_valid on a clock edge (accept):
  - divisor==0 -> DONE; div_zero=1, quotient=all ones, remainder=0.
  - else dividend[2N-1:N] >= divisor -> DONE; overflow=1, quotient=all ones, remainder=0.
  - else load R (N+1 bits) = {0, dividend[2N-1:N]}, Q = dividend[N-1:0], D = divisor, cnt = N -> CALC.
  - div_zero takes priority over overflow; at most one flag is set.
- CALC, each edge:
  - shift {R,Q} left 1 bit.
  - T = R - {0,D}. If T is non-negative, R = T and Q[0]=1, else Q[0]=0.
  - cnt decrements; after the step where cnt was 1 -> DONE, quotient=Q, remainder=R[N-1:0].
- Latency: out_valid rises N edges after the accepting edge (16 for default). Error paths take 1 edge.
- Invariant: R < D after every step, so N+1 bits never overflow.
- DONE: outputs held stable while out_ready=0. On an edge with out_ready=1 -> IDLE, out_valid=0; flags and outputs keep their values.
- No acceptance in DONE. No new input is taken on the same edge as output release; one-cycle bubble.
- in_valid outside IDLE is ignored; the source must hold it until in_ready.
- Input values are sampled only on the accept edge; later changes have no effect.
- Arithmetic is unsigned throughout; no rounding.

Optional Feature:
- Macro APPROX_DIV_EN.
- Defined:
  - CALC runs N-APPROX_BITS steps only.
  - quotient = exact quotient with its low APPROX_BITS bits forced to 0.
  - remainder output is forced to 0.
  - Latency is N-APPROX_BITS.
  - Error paths are unchanged.
- Not defined: exact behaviour above; APPROX_BITS is ignored.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE}.
  - default width constant DIV_N=16.
  - counter width derived as clog2(N+1).
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: R, Q, D.
  - Outputs: next R, next Q.
  - Instantiated once; the FSM/counter lives in the top.

Test Plan:
- Exact: dividend=0x000186A0, divisor=0x012C -> after 16 cycles quotient=0x014D, remainder=0x0064, flags 0.
- Max: dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0x0000. Also dividend=0x00010000, divisor=0x0002 -> quotient=0x8000, remainder=0.
- Errors:
  - divisor=0 -> out_valid after 1 cycle, div_zero=1, quotient=0xFFFF, remainder=0.
  - dividend=0x00020000, divisor=0x0002 -> overflow=1, div_zero=0.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is ignored; on release the block returns to IDLE and accepts the next op with correct result.
- Reset: rst_n pulsed low at CALC step 7 -> all outputs 0 and in_ready=1 asynchronously; the next op completes correctly.
- APPROX_DIV_EN with APPROX_BITS=4: 0x000186A0 / 0x012C -> quotient=0x0140, remainder=0, latency 12 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// the default operand width and the iteration-counter width helper.
package div_pkg;

   localparam int DIV_N = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Counter must hold the value N itself, hence N+1 distinct values.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q} left by one,
// trial-subtract the divisor and keep the difference only when it fits.
module div_step
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic [N:0]   r_i,
   input  logic [N-1:0] q_i,
   input  logic [N-1:0] d_i,
   output logic [N:0]   r_o,
   output logic [N-1:0] q_o
);

   logic [N+1:0] shifted_s;
   logic [N:0]   diff_s;
   logic         fits_s;

   // Shift, trial-subtract and restore on borrow.
   always_comb begin
      shifted_s = {r_i, q_i[N-1]};
      diff_s    = shifted_s[N:0] - {1'b0, d_i};
      fits_s    = (shifted_s >= {2'b00, d_i});
      if (fits_s) begin
         r_o = diff_s;
         q_o = {q_i[N-2:0], 1'b1};
      end else begin
         r_o = shifted_s[N:0];
         q_o = {q_i[N-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, ready/valid on both sides. Divide-by-zero and quotient
// overflow are detected at acceptance and answered in a single edge.
// Optional build macro APPROX_DIV_EN: runs only N-APPROX_BITS iterations,
// returns the quotient with its low APPROX_BITS bits cleared and a zero
// remainder. Without the macro the divider is exact and APPROX_BITS is inert.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int N           = DIV_N,
   parameter int APPROX_BITS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_zero,
   output logic           overflow
);

`ifdef APPROX_DIV_EN
   localparam bit APPROX_EN = 1'b1;
`else
   localparam bit APPROX_EN = 1'b0;
`endif

   localparam int SKIP  = APPROX_EN ? APPROX_BITS : 0;
   localparam int STEPS = N - SKIP;
   localparam int CNT_W = cnt_width(N);

   div_state_e      state_q, state_d;
   logic [N:0]      r_q, r_d;
   logic [N-1:0]    q_q, q_d;
   logic [N-1:0]    d_q, d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]    quotient_q, quotient_d;
   logic [N-1:0]    remainder_q, remainder_d;
   logic            div_zero_q, div_zero_d;
   logic            overflow_q, overflow_d;

   logic [N:0]      r_next_s;
   logic [N-1:0]    q_next_s;

   div_step #(.N(N)) u_step (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (d_q),
      .r_o (r_next_s),
      .q_o (q_next_s)
   );

   // Next-state logic: acceptance/error screening, iteration and release.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      overflow_d  = overflow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == {N{1'b0}}) begin
                  div_zero_d  = 1'b1;
                  overflow_d  = 1'b0;
                  quotient_d  = {N{1'b1}};
                  remainder_d = {N{1'b0}};
                  state_d     = DONE;
               end else if (dividend[2*N-1:N] >= divisor) begin
                  // High half >= divisor means the quotient needs > N bits.
                  div_zero_d  = 1'b0;
                  overflow_d  = 1'b1;
                  quotient_d  = {N{1'b1}};
                  remainder_d = {N{1'b0}};
                  state_d     = DONE;
               end else begin
                  div_zero_d = 1'b0;
                  overflow_d = 1'b0;
                  r_d        = {1'b0, dividend[2*N-1:N]};
                  q_d        = dividend[N-1:0];
                  d_d        = divisor;
                  cnt_d      = CNT_W'(STEPS);
                  state_d    = CALC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            r_d   = r_next_s;
            q_d   = q_next_s;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Low STEPS bits of Q now hold the top quotient bits.
               quotient_d  = q_next_s << SKIP;
               remainder_d = APPROX_EN ? {N{1'b0}} : r_next_s[N-1:0];
               state_d     = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and result registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= {(N+1){1'b0}};
         q_q         <= {N{1'b0}};
         d_q         <= {N{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         quotient_q  <= {N{1'b0}};
         remainder_q <= {N{1'b0}};
         div_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
         overflow_q  <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: a driver pushes the expected
// result of each accepted operation, a monitor compares whenever the DUT
// presents a result, and a consumer applies backpressure on out_ready.
`timescale 1ns/1ps
module tb_seq_restoring_divider;

   localparam int N  = 16;
   localparam int AB = 4;
`ifdef APPROX_DIV_EN
   localparam bit APPROX = 1'b1;
`else
   localparam bit APPROX = 1'b0;
`endif
   localparam int STEPS = APPROX ? (N - AB) : N;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] dividend = 32'd0;
   logic [15:0] divisor = 16'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_zero;
   logic        overflow;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   stall = 0;
   bit   rand_ready = 1'b0;
   bit   prev_valid = 1'b0;

   seq_restoring_divider #(.N(N), .APPROX_BITS(AB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer division plus the error rules.
   function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
      exp_t e;
      logic [31:0] qq;
      e.dz = 1'b0; e.ov = 1'b0; e.acc = 0;
      if (b == 16'd0) begin
         e.dz = 1'b1; e.q = 16'hFFFF; e.r = 16'd0; e.lat = 0;
      end else begin
         qq = a / {16'd0, b};
         if (qq > 32'h0000_FFFF) begin
            e.ov = 1'b1; e.q = 16'hFFFF; e.r = 16'd0; e.lat = 0;
         end else begin
            e.q = qq[15:0];
            e.r = 16'(a % {16'd0, b});
            e.lat = STEPS;
            if (APPROX) begin
               e.q = e.q & ~16'((1 << AB) - 1);
               e.r = 16'd0;
            end
         end
      end
      return e;
   endfunction

   task automatic send(input logic [31:0] a, input logic [15:0] b);
      int t;
      exp_t e;
      t = 0;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
      e = model(a, b);
      e.acc = cyc;
      sb.push_back(e);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         n_checks++; n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding expected 0", sb.size());
      end
   endtask

   // Consumer: drives out_ready between edges, honouring requested stalls.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (stall > 0 && out_valid) begin
            out_ready = 1'b0;
            stall--;
         end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 2) != 0);
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor: compares presented results against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid) begin
               if (sb.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_result: out_valid 1 expected 0");
               end else begin
                  e = sb[0];
                  if (!prev_valid) check("latency", 32'(cyc - e.acc), 32'(e.lat));
                  check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                  check("quotient", {16'd0, quotient}, {16'd0, e.q});
                  check("remainder", {16'd0, remainder}, {16'd0, e.r});
                  check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                  check("overflow", {31'd0, overflow}, {31'd0, e.ov});
                  if (out_ready) void'(sb.pop_front());
               end
            end
            prev_valid = out_valid;
         end
      end
   end

   initial begin
      logic [15:0] b;
      logic [15:0] hi;
      // Reset state
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_quotient", {16'd0, quotient}, 32'd0);
      check("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      send(32'h0001_86A0, 16'h012C);
      send(32'hFFFE_0001, 16'hFFFF);
      send(32'h0001_0000, 16'h0002);
      send(32'h1234_5678, 16'h0000);
      send(32'h0002_0000, 16'h0002);
      send(32'hFFFF_FFFF, 16'hFFFF);
      send(32'h0000_0000, 16'h0001);
      drain();

      // Backpressure: hold the result 5 cycles while the next op waits
      stall = 5;
      send(32'h0000_FFFF, 16'h0003);
      send(32'h00AB_CDEF, 16'h1000);
      drain();

      // Asynchronous reset in the middle of CALC
      send(32'h0005_5555, 16'h0123);
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_outputs", {quotient, remainder}, 32'd0);
      check("arst_flags", {30'd0, div_zero, overflow}, 32'd0);
      sb.delete();
      #3;
      rst_n = 1'b1;
      send(32'h0001_86A0, 16'h012C);
      drain();

      // Randomised operations with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         b = 16'($urandom);
         if (i % 10 == 3) b = 16'd0;
         if (i % 7 == 2) b = 16'($urandom_range(1, 15));
         if (i % 9 == 5 || b == 16'd0) hi = 16'($urandom);
         else hi = 16'($urandom_range(0, int'(b) - 1));
         send({hi, 16'($urandom)}, b);
      end
      drain();
      rand_ready = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time exceeded limit");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
